spi_rom_responder: RTL and testbench
====================================

SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 6, meaning log2 of internal byte memory depth (64 bytes).
REQ-002 SHALL have parameter CMD_READ, default 8'h03, meaning the READ opcode (no dummy byte).
REQ-003 SHALL have parameter CMD_FAST, default 8'h0B, meaning the FAST READ opcode (8 dummy bits).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising clk.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port spi_cs  input  1  chip select, active HIGH.
REQ-007 SHALL have port spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 SHALL have port spi_mosi  input  1  serial command/address from initiator.
REQ-009 SHALL have port spi_miso  output  1  serial read data, MSB first.
REQ-010 SHALL have port load_en  input  1  memory write strobe, clk domain.
REQ-011 SHALL have port load_addr  input  MEM_AW  memory write address.
REQ-012 SHALL have port load_data  input  8  memory write data.
REQ-013 SHALL have port busy  output  1  high while state is not IDLE.
REQ-014 SHALL have port cmd_err  output  1  sticky flag: unsupported opcode received.

Function
REQ-015 SHALL pass spi_cs, spi_sclk, spi_mosi through 2-flop synchronizers; rising/falling SCLK edges detected from the 2nd/3rd stage.
REQ-016 SHALL support SCLK high and low phases of >= 4 clk each; faster SCLK is out of scope.
REQ-017 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-018 IDLE -> CMD when synchronized spi_cs rises; bit counter cleared.
REQ-019 CMD: shift in 8 bits MSB first on synchronized SCLK rising edges; after 8th bit -> ADDR if opcode is CMD_READ or CMD_FAST, else -> IGNORE and set cmd_err.
REQ-020 ADDR: shift in 24 address bits MSB first; after 24th bit -> DUMMY for CMD_FAST, DATA for CMD_READ.
REQ-021 DUMMY: count 8 rising edges, ignore MOSI, then -> DATA.
REQ-022 On entry to DATA, SHALL load shift register from mem[addr[MEM_AW-1:0]] and drive its MSB on spi_miso on the next SCLK falling edge, so it is valid before the following rising edge.
REQ-023 DATA: spi_miso SHALL change only 1 clk after a synchronized SCLK falling edge is detected (3 clk after pin edge), never on a rising edge.
REQ-024 After 8 data bits, 24-bit address SHALL increment by 1 (wrap FFFFFF -> 000000), next byte loaded, streaming continues without gap.
REQ-025 Memory index SHALL be addr[MEM_AW-1:0]; upper address bits ignored (memory aliases).
REQ-026 IGNORE: spi_miso held 0 until spi_cs falls.
REQ-027 spi_cs falling (synchronized) in any state SHALL force IDLE within 1 clk, clear counters, drive spi_miso 0; partial command/address discarded.
REQ-028 spi_miso SHALL be 0 in all states other than DATA.
REQ-029 load_en SHALL write load_data to mem[load_addr] on the rising clk; a simultaneous byte load for DATA at the same address SHALL return the new data (write-first).
REQ-030 cmd_err SHALL clear only on reset; busy SHALL equal (state != IDLE).

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE, spi_miso 0, busy 0, cmd_err 0, counters and shift registers 0, synchronizer flops 0.
REQ-032 Memory contents SHALL NOT be reset; content is undefined until loaded.
REQ-033 Reset asserted mid-transfer SHALL abort; after release, a transfer already in progress (spi_cs high) is ignored until spi_cs falls and rises again.

Verification
REQ-034 Load mem[0x10..0x13]=A5,3C,FF,01; CS high, send 03 000010, clock 32 data bits at SCLK=clk/8 -> MISO bytes A5,3C,FF,01 MSB first.
REQ-035 Send 0B 000013, 8 dummy bits, 16 data bits -> bytes 01 then mem[0x14]; no bit appears during dummy phase.
REQ-036 Send 03 FFFFFF with mem[0x3F]=77, mem[0x00]=88, read 16 bits -> 77, 88 (24-bit wrap and aliasing).
REQ-037 Send opcode 9F then 16 clocks -> MISO all 0, cmd_err=1, busy=1 until CS falls, then busy=0.
REQ-038 Drop CS after 20 address bits, then send 03 000011 -> first byte equals mem[0x11] (partial aborted).
REQ-039 Assert reset_n low during DATA phase -> spi_miso=0, busy=0 immediately; cmd_err=0; no data until a new CS cycle.

Source files
------------

// File: rtl/spi_rom_responder_if.sv
// SPI pin bundle between an initiator and the ROM responder.
// The initiator drives chip select, clock and MOSI; the responder drives MISO.
interface spi_rom_responder_if;
    logic spi_cs;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_rom_responder.sv
// SPI mode-0 READ / FAST READ responder backed by a clk-domain loadable byte memory.
// SPI pins are oversampled in the clk domain; SCLK must stay high and low for >= 4 clk each.
module spi_rom_responder #(
    parameter int          MEM_AW   = 6,
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter logic [7:0]  CMD_FAST = 8'h0B
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_rom_responder_if.slave spi,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              cmd_err
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    state_t      state;
    logic        cs_s1, cs_s2, cs_s3;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  sync_cnt;
    logic        cs_armed;
    logic [4:0]  bit_cnt;
    logic [7:0]  opcode;
    logic [23:0] addr;
    logic [7:0]  shift_reg;
    logic        miso_reg;
    logic        is_fast;
    logic        fetch_reg;
    logic        load_reg;
    logic        cmd_err_reg;

    logic [7:0]  mem [0:(1<<MEM_AW)-1];
    logic [7:0]  rd_data;

    logic        sclk_rise, sclk_fall, cs_rise;
    logic [7:0]  opcode_in;
    logic [23:0] addr_in;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3 & cs_armed;
    assign opcode_in = {opcode[6:0], mosi_s2};
    assign addr_in   = {addr[22:0], mosi_s2};

    assign spi.spi_miso = miso_reg;
    assign busy         = (state != IDLE);
    assign cmd_err      = cmd_err_reg;

    // Synchronizers. The chip-select edge detector is only armed once a settled
    // low level has been seen, so a transfer already running at reset release is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_s1    <= 1'b0;
            cs_s2    <= 1'b0;
            cs_s3    <= 1'b0;
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            sync_cnt <= 2'd0;
            cs_armed <= 1'b0;
        end else begin
            cs_s1   <= spi.spi_cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= spi.spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi.spi_mosi;
            mosi_s2 <= mosi_s1;
            if (sync_cnt != 2'd2) begin
                sync_cnt <= sync_cnt + 2'd1;
            end else if (!cs_s2) begin
                cs_armed <= 1'b1;
            end
        end
    end

    // Byte memory: no reset, registered read with write-first bypass.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (fetch_reg) begin
            if (load_en && (load_addr == addr[MEM_AW-1:0])) begin
                rd_data <= load_data;
            end else begin
                rd_data <= mem[addr[MEM_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 5'd0;
            opcode      <= 8'd0;
            addr        <= 24'd0;
            shift_reg   <= 8'd0;
            miso_reg    <= 1'b0;
            is_fast     <= 1'b0;
            fetch_reg   <= 1'b0;
            load_reg    <= 1'b0;
            cmd_err_reg <= 1'b0;
        end else begin
            fetch_reg <= 1'b0;
            load_reg  <= fetch_reg;
            if (load_reg) begin
                shift_reg <= rd_data;
            end

            if (state != IDLE && !cs_s2) begin
                state     <= IDLE;
                bit_cnt   <= 5'd0;
                opcode    <= 8'd0;
                addr      <= 24'd0;
                shift_reg <= 8'd0;
                miso_reg  <= 1'b0;
                fetch_reg <= 1'b0;
                load_reg  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        miso_reg <= 1'b0;
                        if (cs_rise) begin
                            state   <= CMD;
                            bit_cnt <= 5'd0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            opcode <= opcode_in;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                is_fast <= (opcode_in == CMD_FAST);
                                if (opcode_in == CMD_READ || opcode_in == CMD_FAST) begin
                                    state <= ADDR;
                                end else begin
                                    state       <= IGNORE;
                                    cmd_err_reg <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr <= addr_in;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= 5'd0;
                                if (is_fast) begin
                                    state <= DUMMY;
                                end else begin
                                    state     <= DATA;
                                    fetch_reg <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= 5'd0;
                                state     <= DATA;
                                fetch_reg <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        // Next byte is fetched right after the last bit leaves, well before the next fall.
                        if (sclk_fall) begin
                            miso_reg  <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= 5'd0;
                                addr      <= addr + 24'd1;
                                fetch_reg <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    IGNORE: begin
                        miso_reg <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        miso_reg <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed bench for spi_rom_responder: SPI initiator at SCLK = clk/8, hand-computed bytes.
module tb_spi_rom_responder;
    logic       clk;
    logic       reset_n;
    logic       load_en;
    logic [5:0] load_addr;
    logic [7:0] load_data;
    logic       busy;
    logic       cmd_err;

    int vectors;
    int miscompares;

    spi_rom_responder_if spi_bus ();

    spi_rom_responder #(
        .MEM_AW  (6),
        .CMD_READ(8'h03),
        .CMD_FAST(8'h0B)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi      (spi_bus.slave),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mem_load(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // One SCLK period: MOSI set with SCLK low, MISO sampled just before the rising edge.
    task automatic xfer_bit(input logic mosi_v, output logic miso_v);
        spi_bus.spi_mosi = mosi_v;
        wait_clk(4);
        miso_v = spi_bus.spi_miso;
        spi_bus.spi_sclk = 1'b1;
        wait_clk(4);
        spi_bus.spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        logic m;
        for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], m);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic m;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b0, m);
            b[i] = m;
        end
    endtask

    task automatic clock_idle(input int n, output logic any_one);
        logic m;
        any_one = 1'b0;
        for (int i = 0; i < n; i++) begin
            xfer_bit(1'b0, m);
            if (m !== 1'b0) any_one = 1'b1;
        end
    endtask

    task automatic cs_begin;
        @(negedge clk);
        spi_bus.spi_cs = 1'b1;
        wait_clk(4);
    endtask

    task automatic cs_end;
        @(negedge clk);
        spi_bus.spi_cs   = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        wait_clk(6);
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        $display("txn %s: miso byte %h (expected %h)", name, got, exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
        vectors++;
        if (spi_bus.spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", spi_bus.spi_miso); end
        $display("txn reset: busy=%b cmd_err=%b miso=%b", busy, cmd_err, spi_bus.spi_miso);
    endtask

    task automatic test_read;
        logic [7:0] b;
        mem_load(6'h10, 8'hA5);
        mem_load(6'h11, 8'h3C);
        mem_load(6'h12, 8'hFF);
        mem_load(6'h13, 8'h01);
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'h000010, 24);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy: got %b expected 1", busy); end
        recv_byte(b); check_byte("read_b0", b, 8'hA5);
        recv_byte(b); check_byte("read_b1", b, 8'h3C);
        recv_byte(b); check_byte("read_b2", b, 8'hFF);
        recv_byte(b); check_byte("read_b3", b, 8'h01);
        cs_end();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_fast;
        logic [7:0] b;
        logic       any_one;
        mem_load(6'h14, 8'h5A);
        cs_begin();
        send_bits(24'h00000B, 8);
        send_bits(24'h000013, 24);
        clock_idle(8, any_one);
        vectors++;
        $display("txn fast_dummy: any miso bit set=%b", any_one);
        if (any_one !== 1'b0) begin miscompares++; $display("FAIL fast_dummy: got %b expected 0", any_one); end
        recv_byte(b); check_byte("fast_b0", b, 8'h01);
        recv_byte(b); check_byte("fast_b1", b, 8'h5A);
        cs_end();
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        mem_load(6'h3F, 8'h77);
        mem_load(6'h00, 8'h88);
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'hFFFFFF, 24);
        recv_byte(b); check_byte("wrap_b0", b, 8'h77);
        recv_byte(b); check_byte("wrap_b1", b, 8'h88);
        cs_end();
    endtask

    task automatic test_bad_opcode;
        logic any_one;
        cs_begin();
        send_bits(24'h00009F, 8);
        clock_idle(16, any_one);
        $display("txn bad_opcode: any miso=%b cmd_err=%b busy=%b", any_one, cmd_err, busy);
        vectors++;
        if (any_one !== 1'b0) begin miscompares++; $display("FAIL bad_miso: got %b expected 0", any_one); end
        vectors++;
        if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL bad_cmd_err: got %b expected 1", cmd_err); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL bad_busy: got %b expected 1", busy); end
        cs_end();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_busy_end: got %b expected 0", busy); end
        vectors++;
        if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL bad_cmd_err_sticky: got %b expected 1", cmd_err); end
    endtask

    task automatic test_abort;
        logic [7:0] b;
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'h000000, 20);
        cs_end();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'h000011, 24);
        recv_byte(b); check_byte("abort_b0", b, 8'h3C);
        cs_end();
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        logic       any_one;
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'h000012, 24);
        send_bits(24'h000000, 1);
        #2 reset_n = 1'b0;
        #1;
        $display("txn reset_mid: miso=%b busy=%b cmd_err=%b", spi_bus.spi_miso, busy, cmd_err);
        vectors++;
        if (spi_bus.spi_miso !== 1'b0) begin miscompares++; $display("FAIL rst_miso: got %b expected 0", spi_bus.spi_miso); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++;
        if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_err: got %b expected 0", cmd_err); end
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
        send_bits(24'h000003, 8);
        clock_idle(16, any_one);
        vectors++;
        if (any_one !== 1'b0) begin miscompares++; $display("FAIL rst_stale_miso: got %b expected 0", any_one); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_stale_busy: got %b expected 0", busy); end
        cs_end();
        cs_begin();
        send_bits(24'h000003, 8);
        send_bits(24'h000012, 24);
        recv_byte(b); check_byte("rst_new_b0", b, 8'hFF);
        cs_end();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset_n          = 1'b0;
        load_en          = 1'b0;
        load_addr        = 6'h00;
        load_data        = 8'h00;
        spi_bus.spi_cs   = 1'b0;
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(5);

        test_reset();
        test_read();
        test_fast();
        test_wrap();
        test_bad_opcode();
        test_abort();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
